// File: rtl/amp_decim_pkg.sv
// Shared types, default widths and the shift/round/saturate helper for amp_decim_scale.
package amp_decim_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_DECIM_LOG2 = 4;
    localparam int DEF_SCALE_W    = 4;
    localparam int ACC_W          = DEF_DATA_WIDTH + DEF_DECIM_LOG2;

    // Working width of sat_shift; wide enough for any practical DATA_WIDTH plus gain.
    localparam int CALC_W = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCALE = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Returns {sat, res}: s > 0 shifts left and saturates to 2^dw-1,
    // s < 0 shifts right with optional round-half-up, s = 0 passes avg through.
    function automatic logic [CALC_W:0] sat_shift(
        input logic [CALC_W-1:0] avg,
        input int                s,
        input logic              round_en,
        input int                dw
    );
        logic [CALC_W-1:0] lim;
        logic [CALC_W-1:0] res;
        logic [CALC_W-1:0] half;
        logic              sat;
        int                a;
        lim  = (CALC_W'(1) << dw) - CALC_W'(1);
        res  = avg;
        half = '0;
        sat  = 1'b0;
        a    = 0;
        if (s > 0) begin
            res = avg << s;
            if (res > lim) begin
                res = lim;
                sat = 1'b1;
            end
        end else if (s < 0) begin
            a    = -s;
            half = round_en ? (CALC_W'(1) << (a - 1)) : '0;
            res  = (avg + half) >> a;
            if (res > lim) begin
                res = lim;
            end
        end
        return {sat, res};
    endfunction

endpackage

// File: rtl/amp_scale_sat.sv
// Pure combinational gain/attenuation stage: signed power-of-two shift with rounding and saturation.
module amp_scale_sat
    import amp_decim_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SCALE_W    = DEF_SCALE_W
) (
    input  logic [DATA_WIDTH-1:0]     avg,
    input  logic signed [SCALE_W-1:0] scale_sel,
    input  logic                      round_en,
    output logic [DATA_WIDTH-1:0]     res,
    output logic                      sat
);

    logic [CALC_W:0] packed_res;

    // Widen, shift/round/clamp, then narrow back; clamping guarantees the upper bits are zero.
    always_comb begin
        packed_res = sat_shift(CALC_W'(avg), int'(scale_sel), round_en, DATA_WIDTH);
        res        = DATA_WIDTH'(packed_res[CALC_W-1:0]);
        sat        = packed_res[CALC_W];
    end

endmodule

// File: rtl/amp_decim_scale.sv
// Block averager between ADC and DAC FIFOs: reads 2^DECIM_LOG2 samples, averages, scales, writes one result.
module amp_decim_scale
    import amp_decim_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
    parameter int SCALE_W    = DEF_SCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  infifo_almst_empty,
    output logic                  infifo_rd_en,
    input  logic [DATA_WIDTH-1:0] infifo_dout,
    input  logic                  outfifo_almst_full,
    output logic                  outfifo_wr_en,
    output logic [DATA_WIDTH-1:0] outfifo_din,
    input  logic                  inbusy,
    input  logic [SCALE_W-1:0]    scale_sel,
    input  logic                  round_en,
    output logic                  sat_flag,
    output logic                  blk_done
);

    localparam int ACC_BITS = DATA_WIDTH + DECIM_LOG2;
    localparam int CNT_W    = DECIM_LOG2 + 1;
    localparam logic [CNT_W-1:0]  BLK_LEN  = CNT_W'(2 ** DECIM_LOG2);
    localparam logic [ACC_BITS:0] AVG_HALF = (ACC_BITS + 1)'((2 ** DECIM_LOG2) / 2);

    state_t                     state;
    logic [ACC_BITS-1:0]        acc;
    logic [CNT_W-1:0]           issued;
    logic                       data_pending;
    logic signed [SCALE_W-1:0]  scale_lat;
    logic                       round_lat;
    logic [DATA_WIDTH-1:0]      res_reg;
    logic [DATA_WIDTH-1:0]      last_din;
    logic [ACC_BITS:0]          acc_rounded;
    logic [DATA_WIDTH-1:0]      avg;
    logic [DATA_WIDTH-1:0]      scaled;
    logic                       scaled_sat;

    // Reads only in ACCUM, only until the block is issued, and never while reset is held.
    assign infifo_rd_en  = !rst && (state == ACCUM) && (issued != BLK_LEN)
                           && !(infifo_almst_empty || inbusy);
    assign outfifo_wr_en = !rst && (state == WRITE) && !outfifo_almst_full;
    assign blk_done      = outfifo_wr_en;
    assign outfifo_din   = outfifo_wr_en ? res_reg : last_din;

    // The extra accumulator bit absorbs the rounding term; the sum itself never exceeds ACC_BITS.
    assign acc_rounded = {1'b0, acc} + (round_lat ? AVG_HALF : '0);
    assign avg         = DATA_WIDTH'(acc_rounded >> DECIM_LOG2);

    amp_scale_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .SCALE_W    (SCALE_W)
    ) u_scale_sat (
        .avg       (avg),
        .scale_sel (scale_lat),
        .round_en  (round_lat),
        .res       (scaled),
        .sat       (scaled_sat)
    );

    // Block sequencer: accumulate the read-latency-delayed data, scale once, then hand off to the output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            issued       <= '0;
            data_pending <= 1'b0;
            scale_lat    <= '0;
            round_lat    <= 1'b0;
            res_reg      <= '0;
            last_din     <= '0;
            sat_flag     <= 1'b0;
        end else begin
            data_pending <= infifo_rd_en;
            if (infifo_rd_en) begin
                issued <= issued + CNT_W'(1);
                if (issued == '0) begin
                    scale_lat <= scale_sel;
                    round_lat <= round_en;
                end
            end
            case (state)
                ACCUM: begin
                    if (data_pending) begin
                        acc <= acc + ACC_BITS'(infifo_dout);
                        if (issued == BLK_LEN) begin
                            state <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    res_reg  <= scaled;
                    sat_flag <= sat_flag | scaled_sat;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (outfifo_wr_en) begin
                        last_din <= res_reg;
                        acc      <= '0;
                        issued   <= '0;
                        state    <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
